// File: rtl/wb_stage_lsu.sv
// Writeback stage with its own pipeline register: waits for late load data,
// extracts/extends sub-word loads, commits to the register file and debug trace.
module wb_stage_lsu #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int PC_W     = 32,
  parameter int CANCEL_W = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_to_wb_valid,
  output logic                        wb_allow_in,
  input  logic [PC_W-1:0]             in_pc,
  input  logic                        in_rf_we,
  input  logic [RADDR_W-1:0]          in_rf_waddr,
  input  logic                        in_res_from_mem,
  input  logic [1:0]                  in_ld_size,
  input  logic                        in_ld_unsigned,
  input  logic [$clog2(DATA_W/8)-1:0] in_addr_lo,
  input  logic [DATA_W-1:0]           in_alu_result,
  input  logic                        flush,
  input  logic                        data_ok,
  input  logic [DATA_W-1:0]           rdata,
  output logic                        rf_we,
  output logic [RADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic                        wb_fwd_valid,
  output logic                        cancel_overflow,
  output logic [PC_W-1:0]             debug_wb_pc,
  output logic [DATA_W/8-1:0]         debug_wb_rf_we,
  output logic [RADDR_W-1:0]          debug_wb_rf_wnum,
  output logic [DATA_W-1:0]           debug_wb_rf_wdata
);

  localparam int OFF_W = $clog2(DATA_W/8);
  localparam logic [CANCEL_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                we_q, we_d;
  logic [RADDR_W-1:0]  waddr_q, waddr_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [OFF_W-1:0]    lo_q, lo_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [CANCEL_W-1:0] cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                capture, cnt_zero, cnt_inc, cnt_dec;

  // Offset bits below the access size are ignored, so misaligned offsets round down.
  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] data,
                                                input logic [1:0]        size,
                                                input logic              uns,
                                                input logic [OFF_W-1:0]  lo);
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] mask;
    logic              sign;
    off = lo;
    case (size)
      2'd0:    ;
      2'd1:    off[0] = 1'b0;
      2'd2:    off[1:0] = 2'b00;
      default: off = '0;
    endcase
    sh = data >> {off, 3'b000};
    case (size)
      2'd0:    begin mask = DATA_W'(8'hFF);         sign = sh[7];        end
      2'd1:    begin mask = DATA_W'(16'hFFFF);      sign = sh[15];       end
      2'd2:    begin mask = DATA_W'(32'hFFFF_FFFF); sign = sh[31];       end
      default: begin mask = '1;                     sign = sh[DATA_W-1]; end
    endcase
    return (sh & mask) | ((!uns && sign) ? ~mask : '0);
  endfunction

  assign wb_allow_in = (state_q == IDLE || state_q == DONE) && !flush;
  assign capture     = mem_to_wb_valid && wb_allow_in;
  assign cnt_zero    = (cnt_q == '0);
  // A flushed load whose own response arrives in the same cycle leaves nothing outstanding.
  assign cnt_inc     = (state_q == WAIT) && flush && !(data_ok && cnt_zero);
  assign cnt_dec     = data_ok && !cnt_zero;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    we_d     = we_q;
    waddr_d  = waddr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    lo_d     = lo_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    case (state_q)
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (data_ok && cnt_zero) begin
          state_d  = DONE;
          result_d = extract(rdata, size_q, uns_q, lo_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (capture) begin
      state_d  = in_res_from_mem ? WAIT : DONE;
      pc_d     = in_pc;
      we_d     = in_rf_we;
      waddr_d  = in_rf_waddr;
      size_d   = in_ld_size;
      uns_d    = in_ld_unsigned;
      lo_d     = in_addr_lo;
      result_d = in_alu_result;
    end

    if (cnt_inc && !cnt_dec) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CANCEL_W'(1);
    end else if (cnt_dec && !cnt_inc) begin
      cnt_d = cnt_q - CANCEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      lo_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rf_we             = (state_q == DONE) && we_q;
  assign rf_waddr          = waddr_q;
  assign rf_wdata          = result_q;
  assign wb_fwd_valid      = (state_q != IDLE) && we_q;
  assign cancel_overflow   = ovf_q;
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_we    = {(DATA_W/8){rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage_lsu.sv
// Bench for wb_stage_lsu: a 32-bit instance and a 64-bit CANCEL_W=1 instance,
// directed scenarios followed by random traffic against a transaction-level model.
module tb_wb_stage_lsu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        i_valid[2];
  logic [31:0] i_pc[2];
  logic        i_we[2];
  logic [4:0]  i_waddr[2];
  logic        i_load[2];
  logic [1:0]  i_size[2];
  logic        i_uns[2];
  logic [2:0]  i_lo[2];
  logic [63:0] i_alu[2];
  logic        i_flush[2];
  logic        i_dok[2];
  logic [63:0] i_rdata[2];

  logic a0_allow, a0_we, a0_fwd, a0_ovf;
  logic [4:0] a0_waddr, a0_dnum;
  logic [31:0] a0_wdata, a0_dwdata, a0_dpc;
  logic [3:0] a0_dwe;
  logic a1_allow, a1_we, a1_fwd, a1_ovf;
  logic [4:0] a1_waddr, a1_dnum;
  logic [63:0] a1_wdata, a1_dwdata;
  logic [31:0] a1_dpc;
  logic [7:0] a1_dwe;

  wb_stage_lsu #(.DATA_W(32), .RADDR_W(5), .PC_W(32), .CANCEL_W(2)) dut0 (
    .clk(clk), .reset(reset), .mem_to_wb_valid(i_valid[0]), .wb_allow_in(a0_allow),
    .in_pc(i_pc[0]), .in_rf_we(i_we[0]), .in_rf_waddr(i_waddr[0]),
    .in_res_from_mem(i_load[0]), .in_ld_size(i_size[0]), .in_ld_unsigned(i_uns[0]),
    .in_addr_lo(i_lo[0][1:0]), .in_alu_result(i_alu[0][31:0]), .flush(i_flush[0]),
    .data_ok(i_dok[0]), .rdata(i_rdata[0][31:0]), .rf_we(a0_we), .rf_waddr(a0_waddr),
    .rf_wdata(a0_wdata), .wb_fwd_valid(a0_fwd), .cancel_overflow(a0_ovf),
    .debug_wb_pc(a0_dpc), .debug_wb_rf_we(a0_dwe), .debug_wb_rf_wnum(a0_dnum),
    .debug_wb_rf_wdata(a0_dwdata));

  wb_stage_lsu #(.DATA_W(64), .RADDR_W(5), .PC_W(32), .CANCEL_W(1)) dut1 (
    .clk(clk), .reset(reset), .mem_to_wb_valid(i_valid[1]), .wb_allow_in(a1_allow),
    .in_pc(i_pc[1]), .in_rf_we(i_we[1]), .in_rf_waddr(i_waddr[1]),
    .in_res_from_mem(i_load[1]), .in_ld_size(i_size[1]), .in_ld_unsigned(i_uns[1]),
    .in_addr_lo(i_lo[1]), .in_alu_result(i_alu[1]), .flush(i_flush[1]),
    .data_ok(i_dok[1]), .rdata(i_rdata[1]), .rf_we(a1_we), .rf_waddr(a1_waddr),
    .rf_wdata(a1_wdata), .wb_fwd_valid(a1_fwd), .cancel_overflow(a1_ovf),
    .debug_wb_pc(a1_dpc), .debug_wb_rf_we(a1_dwe), .debug_wb_rf_wnum(a1_dnum),
    .debug_wb_rf_wdata(a1_dwdata));

  int n_total = 0;
  int n_pass  = 0;
  int pulses0 = 0;

  // Transaction-level model: the instruction held in WB, whether its data is
  // still outstanding, and how many cancelled responses are still in flight.
  bit          m_have[2], m_pend[2], m_we[2], m_uns[2], m_ovf[2];
  logic [31:0] m_pc[2];
  logic [4:0]  m_waddr[2];
  logic [1:0]  m_size[2];
  int          m_lo[2];
  logic [63:0] m_result[2];
  int          m_cnt[2];
  int          cmax[2];

  function automatic logic [63:0] wmask(int i);
    return (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] ext(int w, logic [1:0] sz, bit uns, int lo, logic [63:0] rd);
    int nb;
    int off;
    logic [63:0] v;
    logic [63:0] m;
    nb  = 1 << sz;
    off = (lo / nb) * nb;
    v   = rd >> (8 * off);
    if (nb < 8) begin
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if (!uns && v[8*nb-1]) v = v | ~m;
    end
    if (w == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_have[i] = 0; m_pend[i] = 0; m_we[i] = 0; m_uns[i] = 0; m_ovf[i] = 0;
      m_pc[i] = '0; m_waddr[i] = '0; m_size[i] = '0; m_lo[i] = 0;
      m_result[i] = '0; m_cnt[i] = 0;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      i_valid[i] = 0; i_pc[i] = '0; i_we[i] = 0; i_waddr[i] = '0; i_load[i] = 0;
      i_size[i] = '0; i_uns[i] = 0; i_lo[i] = '0; i_alu[i] = '0; i_flush[i] = 0;
      i_dok[i] = 0; i_rdata[i] = '0;
    end
  endtask

  task automatic issue(int i, logic [31:0] pc, bit we, logic [4:0] wa, bit ld,
                       logic [1:0] sz, bit uns, int lo, logic [63:0] alu);
    i_valid[i] = 1; i_pc[i] = pc; i_we[i] = we; i_waddr[i] = wa; i_load[i] = ld;
    i_size[i] = sz; i_uns[i] = uns; i_lo[i] = 3'(lo); i_alu[i] = alu;
  endtask

  task automatic resp(int i, logic [63:0] rd);
    i_dok[i] = 1; i_rdata[i] = rd;
  endtask

  // Called at a falling edge with inputs already applied: compare, advance model.
  task automatic tick();
    logic a_allow, a_we, a_fwd, a_ovf;
    logic [4:0] a_waddr, a_dnum;
    logic [63:0] a_wdata, a_dwdata;
    logic [31:0] a_dpc;
    logic [7:0] a_dwe;
    bit ready, allow, dec, cancel, deliver, inc;
    int old;
    #1;
    if (a0_we) pulses0++;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        a_allow = a0_allow; a_we = a0_we; a_fwd = a0_fwd; a_ovf = a0_ovf;
        a_waddr = a0_waddr; a_dnum = a0_dnum; a_wdata = {32'b0, a0_wdata};
        a_dwdata = {32'b0, a0_dwdata}; a_dpc = a0_dpc; a_dwe = {4'b0, a0_dwe};
      end else begin
        a_allow = a1_allow; a_we = a1_we; a_fwd = a1_fwd; a_ovf = a1_ovf;
        a_waddr = a1_waddr; a_dnum = a1_dnum; a_wdata = a1_wdata;
        a_dwdata = a1_dwdata; a_dpc = a1_dpc; a_dwe = a1_dwe;
      end
      ready = m_have[i] && !m_pend[i];
      allow = (!m_have[i] || !m_pend[i]) && !i_flush[i];
      chk($sformatf("i%0d_allow", i), 64'(a_allow), 64'(allow));
      chk($sformatf("i%0d_rf_we", i), 64'(a_we), 64'(ready && m_we[i]));
      chk($sformatf("i%0d_waddr", i), 64'(a_waddr), 64'(m_waddr[i]));
      chk($sformatf("i%0d_wdata", i), a_wdata, m_result[i]);
      chk($sformatf("i%0d_fwd", i), 64'(a_fwd), 64'(m_have[i] && m_we[i]));
      chk($sformatf("i%0d_ovf", i), 64'(a_ovf), 64'(m_ovf[i]));
      chk($sformatf("i%0d_dbg_pc", i), 64'(a_dpc), 64'(m_pc[i]));
      chk($sformatf("i%0d_dbg_we", i), 64'(a_dwe),
          (ready && m_we[i]) ? ((i == 0) ? 64'h0F : 64'hFF) : 64'h0);
      chk($sformatf("i%0d_dbg_wnum", i), 64'(a_dnum), 64'(m_waddr[i]));
      chk($sformatf("i%0d_dbg_wdata", i), a_dwdata, m_result[i]);

      old     = m_cnt[i];
      dec     = i_dok[i] && old > 0;
      cancel  = m_have[i] && m_pend[i] && i_flush[i];
      deliver = m_have[i] && m_pend[i] && !i_flush[i] && i_dok[i] && old == 0;
      inc     = cancel && !(i_dok[i] && old == 0);
      m_cnt[i] = old - (dec ? 1 : 0);
      if (inc) begin
        if (m_cnt[i] == cmax[i]) m_ovf[i] = 1;
        else m_cnt[i]++;
      end
      if (cancel) m_have[i] = 0;
      else if (deliver) begin
        m_result[i] = ext((i == 0) ? 32 : 64, m_size[i], m_uns[i], m_lo[i],
                          i_rdata[i] & wmask(i));
        m_pend[i] = 0;
      end else if (ready) m_have[i] = 0;
      if (i_valid[i] && allow) begin
        m_have[i] = 1; m_pend[i] = i_load[i]; m_pc[i] = i_pc[i]; m_we[i] = i_we[i];
        m_waddr[i] = i_waddr[i]; m_size[i] = i_size[i]; m_uns[i] = i_uns[i];
        m_lo[i] = int'(i_lo[i]); m_result[i] = i_alu[i] & wmask(i);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    cmax[0] = 3;
    cmax[1] = 1;
    reset = 1'b1;
    clr();
    model_reset();
    #3;
    chk("rst_allow0", 64'(a0_allow), 64'd1);
    chk("rst_we0", 64'(a0_we), 64'd0);
    chk("rst_wdata0", 64'(a0_wdata), 64'd0);
    chk("rst_allow1", 64'(a1_allow), 64'd1);
    chk("rst_ovf1", 64'(a1_ovf), 64'd0);
    chk("rst_dpc1", 64'(a1_dpc), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back non-loads
    clr(); issue(0, 32'h100, 1, 5'd1, 0, 2'd0, 0, 0, 64'h11); tick();
    chk("t1_we1", 64'(a0_we), 64'd1); chk("t1_wd1", 64'(a0_wdata), 64'h11);
    clr(); issue(0, 32'h104, 1, 5'd2, 0, 2'd0, 0, 0, 64'h22); tick();
    chk("t1_we2", 64'(a0_we), 64'd1); chk("t1_wd2", 64'(a0_wdata), 64'h22);
    chk("t1_allow", 64'(a0_allow), 64'd1);
    clr(); issue(0, 32'h108, 1, 5'd3, 0, 2'd0, 0, 0, 64'h33); tick();
    chk("t1_we3", 64'(a0_we), 64'd1); chk("t1_wd3", 64'(a0_wdata), 64'h33);
    chk("t1_wa3", 64'(a0_waddr), 64'd3);
    clr(); tick();
    chk("t1_idle_we", 64'(a0_we), 64'd0);

    // LB / LBU at offset 3
    for (int u = 0; u < 2; u++) begin
      clr(); issue(0, 32'h200, 1, 5'd4, 1, 2'd0, bit'(u), 3, 64'h0); tick();
      chk("t2_allow_wait", 64'(a0_allow), 64'd0);
      clr(); tick();
      chk("t2_we_wait", 64'(a0_we), 64'd0);
      clr(); resp(0, 64'h80FF_0000); tick();
      chk("t2_we", 64'(a0_we), 64'd1);
      chk("t2_wdata", 64'(a0_wdata), (u == 1) ? 64'h0000_0080 : 64'hFFFF_FF80);
      clr(); tick();
    end

    // LH aligned and misaligned
    for (int lo = 2; lo < 4; lo++) begin
      clr(); issue(0, 32'h300, 1, 5'd5, 1, 2'd1, 0, lo, 64'h0); tick();
      clr(); resp(0, 64'h7FFF_1234); tick();
      chk("t3_wdata", 64'(a0_wdata), 64'h0000_7FFF);
      clr(); tick();
    end

    // Flushed load's late response dropped; the next load commits its own data
    pulses0 = 0;
    clr(); issue(0, 32'h400, 1, 5'd6, 1, 2'd2, 0, 0, 64'h0); tick();
    clr(); i_flush[0] = 1; tick();
    clr(); tick();
    clr(); issue(0, 32'h404, 1, 5'd7, 1, 2'd2, 0, 0, 64'h0); tick();
    clr(); resp(0, 64'hDEAD_BEEF); tick();
    chk("t4_stale_we", 64'(a0_we), 64'd0);
    clr(); tick();
    clr(); resp(0, 64'h1234_5678); tick();
    chk("t4_we", 64'(a0_we), 64'd1);
    chk("t4_wdata", 64'(a0_wdata), 64'h1234_5678);
    chk("t4_waddr", 64'(a0_waddr), 64'd7);
    clr(); tick(); tick();
    chk("t4_pulses", 64'(pulses0), 64'd1);

    // CANCEL_W=1 overflow, then asynchronous reset in WAIT
    clr(); issue(1, 32'h500, 1, 5'd8, 1, 2'd2, 0, 0, 64'h0); tick();
    clr(); i_flush[1] = 1; tick();
    clr(); issue(1, 32'h504, 1, 5'd8, 1, 2'd2, 0, 0, 64'h0); tick();
    clr(); i_flush[1] = 1; tick();
    chk("t5_ovf", 64'(a1_ovf), 64'd1);
    clr(); tick(); tick();
    chk("t5_ovf_sticky", 64'(a1_ovf), 64'd1);
    clr(); issue(1, 32'h508, 1, 5'd9, 1, 2'd2, 0, 0, 64'h0); tick();
    clr();
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_ovf", 64'(a1_ovf), 64'd0);
    chk("t5_rst_allow", 64'(a1_allow), 64'd1);
    chk("t5_rst_fwd", 64'(a1_fwd), 64'd0);
    chk("t5_rst_dpc", 64'(a1_dpc), 64'd0);
    chk("t5_rst_dwe", 64'(a1_dwe), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // 64-bit LW with sign extension, then LD
    clr(); issue(1, 32'h600, 1, 5'd10, 1, 2'd2, 0, 4, 64'h0); tick();
    clr(); resp(1, 64'h8000_0001_CAFE_BABE); tick();
    chk("t6_lw", a1_wdata, 64'hFFFF_FFFF_8000_0001);
    clr(); issue(1, 32'h604, 1, 5'd11, 1, 2'd3, 0, 0, 64'h0); tick();
    clr(); resp(1, 64'h8000_0001_CAFE_BABE); tick();
    chk("t6_ld", a1_wdata, 64'h8000_0001_CAFE_BABE);
    clr(); tick();

    // Random traffic on both instances
    repeat (4000) begin
      clr();
      for (int i = 0; i < 2; i++) begin
        i_valid[i] = ($urandom_range(0, 9) < 6);
        i_pc[i]    = $urandom;
        i_we[i]    = 1'($urandom);
        i_waddr[i] = 5'($urandom);
        i_load[i]  = 1'($urandom);
        i_size[i]  = (i == 0) ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
        i_uns[i]   = 1'($urandom);
        i_lo[i]    = (i == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        i_alu[i]   = {$urandom, $urandom} & wmask(i);
        i_flush[i] = ($urandom_range(0, 9) == 0);
        i_dok[i]   = ($urandom_range(0, 9) < 3);
        i_rdata[i] = {$urandom, $urandom} & wmask(i);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
